ram_port_arbiter: RTL

Shares the core's single RAM read/write port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). Grants one requester at a time and keeps one transaction outstanding. Issues a one-cycle RAM command and waits for the RAM's registered ready, then returns data and completion to the winner. Sits inside rvcpu between ifu/lsu and the ram_rw_* port; LSU has priority, with a streak limit so fetch is never starved.

---
 rtl/ram_port_arbiter_pkg.sv | 19 +
 rtl/ram_port_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states, transaction owner
// and the fixed fetch access size.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_IFU = 1'b0,
        ARB_OWN_LSU = 1'b1
    } arb_owner_e;

    localparam logic [2:0] ARB_FETCH_SIZE = 3'd3;

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single RAM read/write port between instruction fetch and
// load/store: LSU-priority with a streak limit, one transaction in flight.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int LSU_MAX_STREAK = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                ifu_req_i,
    input  logic [DATA_W-1:0]   ifu_addr_i,
    output logic                ifu_ack_o,
    output logic                ifu_valid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,

    input  logic                lsu_req_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    input  logic [2:0]          lsu_size_i,
    output logic                lsu_ack_o,
    output logic                lsu_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,

    output logic                ram_rw_cen_o,
    output logic                ram_rw_wen_o,
    output logic [DATA_W-1:0]   ram_rw_addr_o,
    output logic [DATA_W-1:0]   ram_rw_wdata_o,
    output logic [DATA_W/8-1:0] ram_rw_wmask_o,
    output logic [2:0]          ram_rw_size_o,
    input  logic                ram_rw_ready_i,
    input  logic [DATA_W-1:0]   ram_rw_data_i,

    output logic                err_o
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(LSU_MAX_STREAK + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LSU_MAX_STREAK);
    // The counter runs 0..TIMEOUT_CYCLES-1 across the WAIT cycles, so the
    // last permitted WAIT cycle is the one where it holds TMO_LAST.
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    arb_state_e            state;
    arb_owner_e            owner;
    logic                  cmd_wen;
    logic [STREAK_W-1:0]   streak;
    logic [TMO_W-1:0]      tmo_cnt;

    logic                  lsu_grant;
    logic                  ifu_grant;

    function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
        return (s == STREAK_MAX) ? s : s + STREAK_W'(1);
    endfunction

    always_comb begin
        lsu_grant = 1'b0;
        ifu_grant = 1'b0;
        if (state == ARB_IDLE) begin
            lsu_grant = lsu_req_i && (!ifu_req_i || (streak < STREAK_MAX));
            ifu_grant = ifu_req_i && !lsu_grant;
        end
    end

    assign ifu_ack_o = ifu_grant;
    assign lsu_ack_o = lsu_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB_IDLE;
            owner          <= ARB_OWN_IFU;
            cmd_wen        <= 1'b0;
            streak         <= '0;
            tmo_cnt        <= '0;
            ram_rw_cen_o   <= 1'b0;
            ram_rw_wen_o   <= 1'b0;
            ram_rw_addr_o  <= '0;
            ram_rw_wdata_o <= '0;
            ram_rw_wmask_o <= '0;
            ram_rw_size_o  <= '0;
            ifu_valid_o    <= 1'b0;
            ifu_rdata_o    <= '0;
            lsu_valid_o    <= 1'b0;
            lsu_rdata_o    <= '0;
            err_o          <= 1'b0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            ram_rw_cen_o <= 1'b0;
            ram_rw_wen_o <= 1'b0;
            ifu_valid_o  <= 1'b0;
            lsu_valid_o  <= 1'b0;
            err_o        <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (lsu_grant) begin
                        owner          <= ARB_OWN_LSU;
                        cmd_wen        <= lsu_wen_i;
                        ram_rw_addr_o  <= lsu_addr_i;
                        ram_rw_wdata_o <= lsu_wdata_i;
                        ram_rw_wmask_o <= lsu_wmask_i;
                        ram_rw_size_o  <= lsu_size_i;
                        ram_rw_cen_o   <= 1'b1;
                        ram_rw_wen_o   <= lsu_wen_i;
                        streak         <= ifu_req_i ? streak_inc(streak) : '0;
                        state          <= ARB_ISSUE;
                    end else if (ifu_grant) begin
                        owner          <= ARB_OWN_IFU;
                        cmd_wen        <= 1'b0;
                        ram_rw_addr_o  <= ifu_addr_i;
                        ram_rw_wdata_o <= '0;
                        ram_rw_wmask_o <= MASK_W'(0);
                        ram_rw_size_o  <= ARB_FETCH_SIZE;
                        ram_rw_cen_o   <= 1'b1;
                        streak         <= '0;
                        state          <= ARB_ISSUE;
                    end
                end

                ARB_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= ARB_WAIT;
                end

                ARB_WAIT: begin
                    // Ready is tested first so a response on the final count
                    // completes normally rather than as a timeout.
                    if (ram_rw_ready_i) begin
                        if (owner == ARB_OWN_IFU) begin
                            ifu_rdata_o <= ram_rw_data_i;
                            ifu_valid_o <= 1'b1;
                        end else begin
                            if (!cmd_wen) lsu_rdata_o <= ram_rw_data_i;
                            lsu_valid_o <= 1'b1;
                        end
                        state <= ARB_RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (owner == ARB_OWN_IFU) begin
                            ifu_rdata_o <= '0;
                            ifu_valid_o <= 1'b1;
                        end else begin
                            if (!cmd_wen) lsu_rdata_o <= '0;
                            lsu_valid_o <= 1'b1;
                        end
                        err_o <= 1'b1;
                        state <= ARB_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ARB_RESP: begin
                    state <= ARB_IDLE;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
